operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32: operand data width.
REQ-002 Parameter NUM_SRC, default 6: number of operand channels per instruction.
REQ-003 Parameter NUM_FWD, default 6: number of forwarding sources.
REQ-004 Parameter SELW, default $clog2(NUM_FWD+1): forward-select width per channel.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low; the ports are named clk and rstn.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 flush  in  1  discard all held and incoming instructions.
REQ-009 in_valid  in  1  upstream instruction valid.
REQ-010 in_ready  out  1  block can accept this cycle.
REQ-011 in_pc  in  32  instruction PC.
REQ-012 in_instr  in  32  instruction word.
REQ-013 rf_data  in  NUM_SRC*XLEN  register-file read data; channel i is bits [i*XLEN +: XLEN].
REQ-014 fwd_sel  in  NUM_SRC*SELW  per-channel forward select.
REQ-015 fwd_data  in  NUM_FWD*XLEN  forwarding results; source k is fwd_data[(k-1)*XLEN +: XLEN].
REQ-016 out_valid  out  1  output instruction valid.
REQ-017 out_ready  in  1  downstream accepts.
REQ-018 out_pc  out  32  held PC.
REQ-019 out_instr  out  32  held instruction.
REQ-020 out_data  out  NUM_SRC*XLEN  held resolved operands.
REQ-021 issue_cnt  out  16  count of completed output transfers.

Function
REQ-022 Per channel: sel==0 -> rf_data; 1<=sel<=NUM_FWD -> fwd source sel; sel>NUM_FWD -> rf_data.
REQ-023 Operands are resolved and captured in the accept cycle (in_valid && in_ready); held values do not track later rf_data/fwd_data changes.
REQ-024 Latency: accepted instruction appears on out_* the next cycle when the output register is empty or draining.
REQ-025 Output transfer: out_valid && out_ready; out_* held stable while out_valid && !out_ready.
REQ-026 Ordering is strict FIFO; no instruction is dropped or duplicated except on flush.
REQ-027 flush (registered): next cycle out_valid=0 and all storage is empty; an input presented in the flush cycle is dropped; in_ready=1 in the cycle after flush.
REQ-028 flush has priority over simultaneous accept and output transfer; issue_cnt still increments for an output transfer in the flush cycle.
REQ-029 issue_cnt increments by 1 per output transfer, wrapping 0xFFFF -> 0x0000.
REQ-030 With an empty block, in_valid held high and out_ready high, throughput is one instruction per cycle.

Reset
REQ-031 rstn low asynchronously clears out_valid=0, skid storage empty, issue_cnt=0, out_pc=0, out_instr=0, out_data=0.
REQ-032 While in reset, in_ready=0; in_ready=1 from the first clock edge after deassertion.
REQ-033 Reset mid-transfer discards all held instructions and does not count them.

Configuration
REQ-034 Macro OPFETCH_SKID_EN defined: two entries (output register plus skid register); in_ready=!skid_full, registered, with no combinational path from out_ready.
REQ-035 OPFETCH_SKID_EN defined: an accept while the output is stalled goes to skid; skid moves to output on the next output transfer; the 2-entry state sets in_ready=0.
REQ-036 OPFETCH_SKID_EN undefined: one entry; in_ready = !out_valid || out_ready (combinational); no skid register.

Verification
REQ-037 Flow: 3 back-to-back instructions, sel=0, rf_data ch0=0x11,0x22,0x33 -> out ch0 0x11,0x22,0x33 on consecutive cycles; issue_cnt=3.
REQ-038 Forward: NUM_FWD=6, ch1 sel=3, fwd src3=0xDEADBEEF; ch2 sel=7 -> ch1=0xDEADBEEF, ch2=rf_data ch2.
REQ-039 Stall (SKID_EN): out_ready=0 for 4 cycles with in_valid=1 -> 2 instructions held, in_ready=0 after the 2nd accept; release -> both emerge in order with values unchanged after fwd_data changes.
REQ-040 Flush: flush with 2 held plus 1 incoming -> next cycle out_valid=0, in_ready=1, and none of the 3 instructions later appear.
REQ-041 Wrap: preload 0xFFFE transfers, then 3 more -> issue_cnt=0x0001.
REQ-042 Reset: assert rstn=0 asynchronously while out_valid=1 -> out_valid=0 and issue_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Operand-fetch handshake bundle: upstream instruction/operand inputs,
// flush, and the downstream held-instruction outputs.
interface operand_fetch_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 6,
  parameter int NUM_FWD = 6,
  parameter int SELW    = $clog2(NUM_FWD + 1)
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_pc;
  logic [31:0]               in_instr;
  logic [NUM_SRC*XLEN-1:0]   rf_data;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_pc;
  logic [31:0]               out_instr;
  logic [NUM_SRC*XLEN-1:0]   out_data;
  logic [15:0]               issue_cnt;

  // Driver side (upstream stage, forwarding network, downstream consumer)
  modport master (
    output flush, in_valid, in_pc, in_instr, rf_data, fwd_sel, fwd_data, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_data, issue_cnt
  );

  // Operand-fetch block side
  modport slave (
    input  flush, in_valid, in_pc, in_instr, rf_data, fwd_sel, fwd_data, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_data, issue_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves each source operand from the register file
// or a forwarding source at accept time and holds the instruction until the
// downstream stage takes it.
// Build option: OPFETCH_SKID_EN adds a skid entry so in_ready is a register
// with no combinational path from out_ready; without it the block is a
// single-entry pipeline register with combinational in_ready.
module operand_fetch #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 6,
  parameter int NUM_FWD = 6,
  parameter int SELW    = $clog2(NUM_FWD + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  operand_fetch_if.slave bus
);

  localparam int DW = NUM_SRC * XLEN;
  localparam int FW = NUM_FWD * XLEN;

  // Select 0 and out-of-range selects fall back to the register file.
  function automatic logic [DW-1:0] resolve_ops(input logic [DW-1:0]          rf,
                                                input logic [NUM_SRC*SELW-1:0] sel,
                                                input logic [FW-1:0]          fwd);
    logic [DW-1:0]   res;
    logic [SELW-1:0] s;
    res = rf;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = sel[i*SELW +: SELW];
      for (int k = 1; k <= NUM_FWD; k++) begin
        if (s == SELW'(k)) res[i*XLEN +: XLEN] = fwd[(k-1)*XLEN +: XLEN];
      end
    end
    return res;
  endfunction

  logic [DW-1:0] in_ops;
  logic          in_ready;
  logic          acc;
  logic          xfer;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_pc_q,    out_pc_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;

  assign in_ops = resolve_ops(bus.rf_data, bus.fwd_sel, bus.fwd_data);
  assign acc    = bus.in_valid && in_ready;
  assign xfer   = out_valid_q && bus.out_ready;

  assign issue_cnt_d = issue_cnt_q + {15'd0, xfer};

`ifdef OPFETCH_SKID_EN
  logic          in_ready_q,  in_ready_d;
  logic          skid_valid_q, skid_valid_d;
  logic [31:0]   skid_pc_q,    skid_pc_d;
  logic [31:0]   skid_instr_q, skid_instr_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;

  assign in_ready = in_ready_q;

  // Next state: output register refills from skid first, new accepts go to
  // whichever entry is free; flush empties both entries.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_data_d  = skid_data_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pc_d     = skid_pc_q;
        out_instr_d  = skid_instr_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
        if (acc) begin
          skid_valid_d = 1'b1;
          skid_pc_d    = bus.in_pc;
          skid_instr_d = bus.in_instr;
          skid_data_d  = in_ops;
        end
      end else if (acc) begin
        out_valid_d = 1'b1;
        out_pc_d    = bus.in_pc;
        out_instr_d = bus.in_instr;
        out_data_d  = in_ops;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = bus.in_pc;
      skid_instr_d = bus.in_instr;
      skid_data_d  = in_ops;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid entry and registered ready
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_data_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  logic rdy_q;

  // Ready only once out of reset, then whenever the output is empty or draining.
  assign in_ready = rdy_q && (!out_valid_q || bus.out_ready);

  // Next state: single entry loads on accept, empties on transfer or flush.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_data_d  = out_data_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (acc) begin
      out_valid_d = 1'b1;
      out_pc_d    = bus.in_pc;
      out_instr_d = bus.in_instr;
      out_data_d  = in_ops;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Post-reset ready enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end
`endif

  // Output register and transfer counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_data_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_data_q  <= out_data_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_data  = out_data_q;
  assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: accepted instructions are modelled and
// queued, and every output transfer is popped and compared.
`timescale 1ns/1ps
module tb_operand_fetch;
  localparam int XLEN    = 32;
  localparam int NUM_SRC = 6;
  localparam int NUM_FWD = 6;
  localparam int SELW    = 3;
  localparam int W       = NUM_SRC * XLEN;
  localparam int FW      = NUM_FWD * XLEN;
  localparam int SW      = NUM_SRC * SELW;
`ifdef OPFETCH_SKID_EN
  localparam int HELD = 2;
`else
  localparam int HELD = 1;
`endif

  logic clk;
  logic rstn;

  operand_fetch_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .SELW(SELW)) bus ();

  operand_fetch #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .SELW(SELW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] expect_ops(input logic [W-1:0] rf,
                                              input logic [SW-1:0] sel,
                                              input logic [FW-1:0] fwd);
    logic [XLEN-1:0] src [NUM_FWD+1];
    logic [W-1:0]    res;
    int              s;
    src[0] = '0;
    for (int k = 1; k <= NUM_FWD; k++) src[k] = fwd[(k-1)*XLEN +: XLEN];
    res = '0;
    for (int c = 0; c < NUM_SRC; c++) begin
      s = int'(sel[c*SELW +: SELW]);
      res[c*XLEN +: XLEN] = (s >= 1 && s <= NUM_FWD) ? src[s] : rf[c*XLEN +: XLEN];
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_sel();
    logic [SW-1:0] v;
    for (int c = 0; c < NUM_SRC; c++) v[c*SELW +: SELW] = SELW'($urandom_range(0, 7));
    return v;
  endfunction

  // Scoreboard: compare transfers first (older entries), then record accepts.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (bus.out_valid && bus.out_ready) begin
        xfers++;
        if (sbq.size() == 0) begin
          chk("sb_underflow", W'(sbq.size()), W'(1));
        end else begin
          e = sbq.pop_front();
          chk("out_pc",    W'(bus.out_pc),    W'(e.pc));
          chk("out_instr", W'(bus.out_instr), W'(e.instr));
          chk("out_data",  bus.out_data,      e.data);
        end
      end
      if (bus.flush) begin
        sbq.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e.pc    = bus.in_pc;
        e.instr = bus.in_instr;
        e.data  = expect_ops(bus.rf_data, bus.fwd_sel, bus.fwd_data);
        sbq.push_back(e);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_instr(input bit rnd_sel);
    bus.in_pc    = $urandom;
    bus.in_instr = $urandom;
    bus.rf_data  = rand_wide();
    bus.fwd_data = FW'(rand_wide());
    bus.fwd_sel  = rnd_sel ? rand_sel() : '0;
  endtask

  task automatic drain(input string tag);
    int n;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((sbq.size() != 0 || bus.out_valid) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, W'(sbq.size()), W'(0));
  endtask

  initial begin
    logic [31:0] flow_v [3];
    int          acc;
    int          n;
    flow_v[0] = 32'h11; flow_v[1] = 32'h22; flow_v[2] = 32'h33;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.rf_data = '0; bus.fwd_sel = '0; bus.fwd_data = '0; bus.out_ready = 1'b0;
    rstn = 1'b0;

    // Reset state, before any clock edge
    #3;
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_in_ready",  W'(bus.in_ready),  W'(0));
    chk("rst_issue_cnt", W'(bus.issue_cnt), W'(0));
    chk("rst_out_pc",    W'(bus.out_pc),    W'(0));
    chk("rst_out_instr", W'(bus.out_instr), W'(0));
    chk("rst_out_data",  bus.out_data,      W'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("ready_before_edge", W'(bus.in_ready), W'(0));
    tick();
    chk("ready_after_rst", W'(bus.in_ready), W'(1));

    // Back-to-back flow, sel=0
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_instr(1'b0);
      bus.rf_data[31:0] = flow_v[i];
      bus.in_valid = 1'b1;
      tick();
      chk("flow_valid", W'(bus.out_valid), W'(1));
      chk("flow_ch0",   W'(bus.out_data[31:0]), W'(flow_v[i]));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("flow_cnt", W'(bus.issue_cnt), W'(3));

    // Forwarding: ch1 from source 3, ch2 select out of range
    new_instr(1'b0);
    bus.fwd_sel = '0;
    bus.fwd_sel[1*SELW +: SELW] = 3'd3;
    bus.fwd_sel[2*SELW +: SELW] = 3'd7;
    bus.fwd_data[2*XLEN +: XLEN] = 32'hDEADBEEF;
    bus.rf_data[0 +: XLEN]       = 32'hC0DE0000;
    bus.rf_data[2*XLEN +: XLEN]  = 32'hC0DE0002;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("fwd_ch0", W'(bus.out_data[0 +: XLEN]),      W'(32'hC0DE0000));
    chk("fwd_ch1", W'(bus.out_data[XLEN +: XLEN]),   W'(32'hDEADBEEF));
    chk("fwd_ch2", W'(bus.out_data[2*XLEN +: XLEN]), W'(32'hC0DE0002));
    drain("fwd_drain");

    // Stall: out_ready low for 4 cycles with upstream always valid
    bus.out_ready = 1'b0;
    acc = 0;
    new_instr(1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.in_ready) begin
        acc++;
        tick();
        new_instr(1'b1);
      end else begin
        tick();
      end
    end
    bus.in_valid = 1'b0;
    chk("stall_held",     W'(acc),           W'(HELD));
    chk("stall_in_ready", W'(bus.in_ready),  W'(0));
    chk("stall_valid",    W'(bus.out_valid), W'(1));
    repeat (2) begin
      bus.fwd_data = FW'(rand_wide());
      bus.rf_data  = rand_wide();
      tick();
    end
    drain("stall_drain");

    // Flush with held entries plus an incoming instruction
    bus.out_ready = 1'b0;
    acc = 0;
    n = 0;
    new_instr(1'b1);
    bus.in_valid = 1'b1;
    while (acc < HELD && n < 10) begin
      if (bus.in_ready) acc++;
      tick();
      new_instr(1'b1);
      n++;
    end
    chk("flush_prefill", W'(acc), W'(HELD));
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", W'(bus.out_valid), W'(0));
    chk("flush_in_ready",  W'(bus.in_ready),  W'(1));
    bus.out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("flush_quiet", W'(bus.out_valid), W'(0));
    end
    chk("flush_cnt", W'(bus.issue_cnt), W'(xfers[15:0]));

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      new_instr(1'b1);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    drain("rand_drain");
    chk("rand_cnt", W'(bus.issue_cnt), W'(xfers[15:0]));

    // Counter wrap: stream up to 0xFFFE transfers, then 3 more
    n = 32'h0000_FFFE - (xfers % 65536);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_pc    = i;
      bus.in_instr = ~i;
      bus.rf_data  = rand_wide();
      bus.fwd_sel  = rand_sel();
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("wrap_pre", W'(bus.issue_cnt), W'(16'hFFFE));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_instr(1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("wrap_post", W'(bus.issue_cnt), W'(16'h0001));

    // Asynchronous reset while holding a valid output
    bus.out_ready = 1'b0;
    new_instr(1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("arst_pre_valid", W'(bus.out_valid), W'(1));
    #2 rstn = 1'b0;
    sbq.delete();
    xfers = 0;
    #1;
    chk("arst_out_valid", W'(bus.out_valid), W'(0));
    chk("arst_cnt",       W'(bus.issue_cnt), W'(0));
    chk("arst_in_ready",  W'(bus.in_ready),  W'(0));
    chk("arst_out_data",  bus.out_data,      W'(0));
    tick();
    rstn = 1'b1;
    tick();
    chk("arst_ready_back", W'(bus.in_ready), W'(1));
    new_instr(1'b1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    drain("arst_drain");
    chk("arst_recount", W'(bus.issue_cnt), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
